temporizador_bcd: RTL and testbench

- mm:ss BCD countdown timer, directly downstream of the one-cycle tick divider; consumes its `CLKOUT` pulse (typ. 1 Hz) on `tick`.
- Drives the divider's enable input through `tick_en`, so the divider only counts while the timer needs ticks.
- Outputs four BCD digits for the 7-segment mux stage, plus a done pulse and an alarm level.

---
 rtl/temporizador_bcd_pkg.sv | 23 ++
 rtl/temporizador_bcd_digit_down.sv | 29 ++
 rtl/temporizador_bcd.sv | 169 ++++++++++++++++
 tb/tb_temporizador_bcd.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/temporizador_bcd_pkg.sv
// Shared definitions for the mm:ss BCD countdown timer.
// Holds the FSM state encoding, the BCD digit limits and the preset clamping helpers.
package temporizador_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] UNIT_MAX = 4'd9;
  localparam logic [2:0] TENS_MAX = 3'd5;

  function automatic logic [3:0] clamp_unit(input logic [3:0] v);
    return (v > UNIT_MAX) ? UNIT_MAX : v;
  endfunction

  function automatic logic [2:0] clamp_tens(input logic [2:0] v);
    return (v > TENS_MAX) ? TENS_MAX : v;
  endfunction

endpackage

// File: rtl/temporizador_bcd_digit_down.sv
// One BCD down-counting digit with synchronous load and a borrow output.
// The borrow is combinational so that a chain of digits decrements in a single edge.
module bcd_digit_down #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dec_in,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] max_val,
  output logic [W-1:0] digit,
  output logic         borrow_out
);

  assign borrow_out = dec_in && (digit == '0);

  // Digit register: load wins, otherwise decrement and wrap to max_val at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_val;
    end else if (dec_in) begin
      digit <= (digit == '0) ? max_val : digit - 1'b1;
    end
  end

endmodule

// File: rtl/temporizador_bcd.sv
// mm:ss BCD countdown timer driven by a one-cycle tick from the divider.
// Optional build macro TEMPORIZADOR_BLINK_EN: alarm blinks at the tick rate in DONE
// instead of staying steadily high.
module temporizador_bcd
  import temporizador_bcd_pkg::*;
#(
  parameter int ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [2:0] pre_mt,
  input  logic [3:0] pre_mu,
  input  logic [2:0] pre_st,
  input  logic [3:0] pre_su,
  output logic [2:0] mt,
  output logic [3:0] mu,
  output logic [2:0] st,
  output logic [3:0] su,
  output logic       tick_en,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

  state_t     state;
  state_t     next_state;
  logic [7:0] alarm_cnt;
  logic       dec;
  logic       load_en;
  logic       done_next;
  logic       alarm_next;
  logic       cnt_clr;
  logic       cnt_inc;
  logic       is_zero;
  logic       is_one;
  logic       su_borrow;
  logic       st_borrow;
  logic       mu_borrow;
  logic       mt_borrow_unused;

  assign is_zero = (mt == 3'd0) && (mu == 4'd0) && (st == 3'd0) && (su == 4'd0);
  assign is_one  = (mt == 3'd0) && (mu == 4'd0) && (st == 3'd0) && (su == 4'd1);

  bcd_digit_down #(.W(4)) u_su (
    .clk(clk), .rst_n(rst_n), .dec_in(dec), .load(load_en),
    .load_val(clamp_unit(pre_su)), .max_val(UNIT_MAX),
    .digit(su), .borrow_out(su_borrow)
  );

  bcd_digit_down #(.W(3)) u_st (
    .clk(clk), .rst_n(rst_n), .dec_in(su_borrow), .load(load_en),
    .load_val(clamp_tens(pre_st)), .max_val(TENS_MAX),
    .digit(st), .borrow_out(st_borrow)
  );

  bcd_digit_down #(.W(4)) u_mu (
    .clk(clk), .rst_n(rst_n), .dec_in(st_borrow), .load(load_en),
    .load_val(clamp_unit(pre_mu)), .max_val(UNIT_MAX),
    .digit(mu), .borrow_out(mu_borrow)
  );

  bcd_digit_down #(.W(3)) u_mt (
    .clk(clk), .rst_n(rst_n), .dec_in(mu_borrow), .load(load_en),
    .load_val(clamp_tens(pre_mt)), .max_val(TENS_MAX),
    .digit(mt), .borrow_out(mt_borrow_unused)
  );

  // Next-state and control decode; load outranks start, which outranks pause.
  always_comb begin
    next_state = state;
    dec        = 1'b0;
    load_en    = 1'b0;
    done_next  = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          load_en = 1'b1;
        end else if (start && !is_zero) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (tick) begin
          dec = 1'b1;
          if (is_one) begin
            next_state = DONE;
            done_next  = 1'b1;
            cnt_clr    = 1'b1;
          end else if (pause) begin
            next_state = PAUSE;
          end
        end else if (pause) begin
          next_state = PAUSE;
        end
      end
      PAUSE: begin
        if (load) begin
          load_en    = 1'b1;
          next_state = IDLE;
        end else if (start) begin
          next_state = RUN;
        end
      end
      DONE: begin
        if (load) begin
          load_en    = 1'b1;
          next_state = IDLE;
        end else if (tick) begin
          if (alarm_cnt == ALARM_LAST) begin
            next_state = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Alarm level for the next cycle: steady in DONE, or blinking per tick when enabled.
  always_comb begin
`ifdef TEMPORIZADOR_BLINK_EN
    alarm_next = 1'b0;
    if (next_state == DONE) begin
      if (state != DONE) begin
        alarm_next = 1'b1;
      end else if (tick) begin
        alarm_next = ~alarm;
      end else begin
        alarm_next = alarm;
      end
    end
`else
    alarm_next = (next_state == DONE);
`endif
  end

  // State, alarm counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alarm_cnt <= 8'd0;
      running   <= 1'b0;
      tick_en   <= 1'b0;
      done      <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state   <= next_state;
      running <= (next_state == RUN);
      tick_en <= (next_state == RUN) || (next_state == DONE);
      done    <= done_next;
      alarm   <= alarm_next;
      if (cnt_clr) begin
        alarm_cnt <= 8'd0;
      end else if (cnt_inc) begin
        alarm_cnt <= alarm_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_temporizador_bcd.sv
// Self-checking bench for temporizador_bcd: a table of per-cycle vectors plus
// hand-written sequences for the alarm timeout and the asynchronous reset.
module tb_temporizador_bcd;

  localparam int ALARM_TICKS = 10;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       load;
  logic       start;
  logic       pause;
  logic [2:0] pre_mt;
  logic [3:0] pre_mu;
  logic [2:0] pre_st;
  logic [3:0] pre_su;
  logic [2:0] mt;
  logic [3:0] mu;
  logic [2:0] st;
  logic [3:0] su;
  logic       tick_en;
  logic       running;
  logic       done;
  logic       alarm;

  int n_cmp;
  int n_err;

  typedef struct {
    string       name;
    logic        ld;
    logic        stt;
    logic        pse;
    logic        tck;
    logic [13:0] pre;
    logic [13:0] exp_d;
    logic [3:0]  exp_f;
  } vec_t;

  typedef struct {
    string       name;
    logic [17:0] exp;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  // Flag groups {running, tick_en, done, alarm}.
  localparam logic [3:0] F_IDLE = 4'b0000;
  localparam logic [3:0] F_RUN  = 4'b1100;

  temporizador_bcd #(.ALARM_TICKS(ALARM_TICKS)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .start(start), .pause(pause),
    .pre_mt(pre_mt), .pre_mu(pre_mu), .pre_st(pre_st), .pre_su(pre_su),
    .mt(mt), .mu(mu), .st(st), .su(su),
    .tick_en(tick_en), .running(running), .done(done), .alarm(alarm)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] d(input int a, input int b, input int c, input int e);
    return {3'(a), 4'(b), 3'(c), 4'(e)};
  endfunction

  function automatic vec_t mk(input string name, input logic ld, input logic stt,
                              input logic pse, input logic tck, input logic [13:0] pre,
                              input logic [13:0] exp_d, input logic [3:0] exp_f);
    vec_t v;
    v.name  = name;
    v.ld    = ld;
    v.stt   = stt;
    v.pse   = pse;
    v.tck   = tck;
    v.pre   = pre;
    v.exp_d = exp_d;
    v.exp_f = exp_f;
    return v;
  endfunction

  // Expected alarm level after k ticks spent in DONE.
  function automatic logic exp_alarm(input int k);
`ifdef TEMPORIZADOR_BLINK_EN
    return (k % 2) == 0;
`else
    return (k >= 0);
`endif
  endfunction

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    load  = v.ld;
    start = v.stt;
    pause = v.pse;
    tick  = v.tck;
    {pre_mt, pre_mu, pre_st, pre_su} = v.pre;
    e.name = v.name;
    e.exp  = {v.exp_d, v.exp_f};
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [17:0] got;
    got = {mt, mu, st, su, running, tick_en, done, alarm};
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("[TB] FAIL scoreboard_empty got=%h required=expected entry", got);
    end else begin
      e = sb.pop_front();
      if (got !== e.exp) begin
        n_err++;
        $display("[TB] FAIL %s got %0d%0d:%0d%0d flags(run,en,done,alarm)=%b required %0d%0d:%0d%0d flags=%b",
                 e.name, got[17:15], got[14:11], got[10:8], got[7:4], got[3:0],
                 e.exp[17:15], e.exp[14:11], e.exp[10:8], e.exp[7:4], e.exp[3:0]);
      end
    end
  endtask

  task automatic step(input vec_t v);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    exp_t e;
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    tick   = 1'b0;
    load   = 1'b0;
    start  = 1'b0;
    pause  = 1'b0;
    pre_mt = '0;
    pre_mu = '0;
    pre_st = '0;
    pre_su = '0;

    // Countdown with borrows, expiry pulse, pause/resume, clamping and priorities.
    tbl.push_back(mk("load_0105",   1, 0, 0, 0, d(0,1,0,5), d(0,1,0,5), F_IDLE));
    tbl.push_back(mk("start_0105",  0, 1, 0, 0, d(0,0,0,0), d(0,1,0,5), F_RUN));
    tbl.push_back(mk("tick_0104",   0, 0, 0, 1, d(0,0,0,0), d(0,1,0,4), F_RUN));
    tbl.push_back(mk("tick_0103",   0, 0, 0, 1, d(0,0,0,0), d(0,1,0,3), F_RUN));
    tbl.push_back(mk("tick_0102",   0, 0, 0, 1, d(0,0,0,0), d(0,1,0,2), F_RUN));
    tbl.push_back(mk("tick_0101",   0, 0, 0, 1, d(0,0,0,0), d(0,1,0,1), F_RUN));
    tbl.push_back(mk("tick_0100",   0, 0, 0, 1, d(0,0,0,0), d(0,1,0,0), F_RUN));
    tbl.push_back(mk("borrow_0059", 0, 0, 0, 1, d(0,0,0,0), d(0,0,5,9), F_RUN));
    tbl.push_back(mk("hold_no_tick",0, 0, 0, 0, d(0,0,0,0), d(0,0,5,9), F_RUN));
    tbl.push_back(mk("pause_0059",  0, 0, 1, 0, d(0,0,0,0), d(0,0,5,9), F_IDLE));
    tbl.push_back(mk("load_0002",   1, 0, 0, 0, d(0,0,0,2), d(0,0,0,2), F_IDLE));
    tbl.push_back(mk("start_0002",  0, 1, 0, 0, d(0,0,0,0), d(0,0,0,2), F_RUN));
    tbl.push_back(mk("tick_0001",   0, 0, 0, 1, d(0,0,0,0), d(0,0,0,1), F_RUN));
    tbl.push_back(mk("expire_done", 0, 0, 0, 1, d(0,0,0,0), d(0,0,0,0), {3'b011, exp_alarm(0)}));
    tbl.push_back(mk("done_1cycle", 0, 0, 0, 0, d(0,0,0,0), d(0,0,0,0), {3'b010, exp_alarm(0)}));
    tbl.push_back(mk("load_0330",   1, 0, 0, 0, d(0,3,3,0), d(0,3,3,0), F_IDLE));
    tbl.push_back(mk("start_0330",  0, 1, 0, 0, d(0,0,0,0), d(0,3,3,0), F_RUN));
    tbl.push_back(mk("tick_pause",  0, 0, 1, 1, d(0,0,0,0), d(0,3,2,9), F_IDLE));
    tbl.push_back(mk("paused_t1",   0, 0, 0, 1, d(0,0,0,0), d(0,3,2,9), F_IDLE));
    tbl.push_back(mk("paused_t2",   0, 0, 0, 1, d(0,0,0,0), d(0,3,2,9), F_IDLE));
    tbl.push_back(mk("paused_t3",   0, 0, 0, 1, d(0,0,0,0), d(0,3,2,9), F_IDLE));
    tbl.push_back(mk("resume",      0, 1, 0, 0, d(0,0,0,0), d(0,3,2,9), F_RUN));
    tbl.push_back(mk("tick_0328",   0, 0, 0, 1, d(0,0,0,0), d(0,3,2,8), F_RUN));
    tbl.push_back(mk("load_in_run", 1, 0, 0, 0, d(4,4,4,4), d(0,3,2,8), F_RUN));
    tbl.push_back(mk("pause_0328",  0, 0, 1, 0, d(0,0,0,0), d(0,3,2,8), F_IDLE));
    tbl.push_back(mk("load_0000",   1, 0, 0, 0, d(0,0,0,0), d(0,0,0,0), F_IDLE));
    tbl.push_back(mk("start_zero",  0, 1, 0, 0, d(0,0,0,0), d(0,0,0,0), F_IDLE));
    tbl.push_back(mk("idle_tick",   0, 0, 0, 1, d(0,0,0,0), d(0,0,0,0), F_IDLE));
    tbl.push_back(mk("clamp_5959",  1, 0, 0, 0, d(7,12,6,15), d(5,9,5,9), F_IDLE));
    tbl.push_back(mk("load_beats_start", 1, 1, 0, 0, d(0,0,1,0), d(0,0,1,0), F_IDLE));
    tbl.push_back(mk("start_0010",  0, 1, 0, 0, d(0,0,0,0), d(0,0,1,0), F_RUN));
    tbl.push_back(mk("tick_0009",   0, 0, 0, 1, d(0,0,0,0), d(0,0,0,9), F_RUN));
    tbl.push_back(mk("pause_0009",  0, 0, 1, 0, d(0,0,0,0), d(0,0,0,9), F_IDLE));

    // Reset state, checked between edges while reset is held.
    #12;
    e.name = "reset_state";
    e.exp  = '0;
    sb.push_back(e);
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
    end

    // Alarm timeout: ALARM_TICKS ticks in DONE return to IDLE; start is ignored meanwhile.
    step(mk("load_0001",  1, 0, 0, 0, d(0,0,0,1), d(0,0,0,1), F_IDLE));
    step(mk("start_0001", 0, 1, 0, 0, d(0,0,0,0), d(0,0,0,1), F_RUN));
    step(mk("expire2",    0, 0, 0, 1, d(0,0,0,0), d(0,0,0,0), {3'b011, exp_alarm(0)}));
    step(mk("start_in_done", 0, 1, 0, 0, d(0,0,0,0), d(0,0,0,0), {3'b010, exp_alarm(0)}));
    for (int k = 1; k < ALARM_TICKS; k++) begin
      step(mk($sformatf("done_tick%0d", k), 0, 0, 0, 1, d(0,0,0,0), d(0,0,0,0),
              {3'b010, exp_alarm(k)}));
    end
    step(mk("alarm_timeout", 0, 0, 0, 1, d(0,0,0,0), d(0,0,0,0), F_IDLE));
    step(mk("idle_after_to", 0, 0, 0, 1, d(0,0,0,0), d(0,0,0,0), F_IDLE));

    // Asynchronous reset mid-RUN at 12:34, asserted between clock edges.
    step(mk("load_1234",  1, 0, 0, 0, d(1,2,3,4), d(1,2,3,4), F_IDLE));
    step(mk("start_1234", 0, 1, 0, 0, d(0,0,0,0), d(1,2,3,4), F_RUN));
    #2;
    rst_n = 1'b0;
    #1;
    e.name = "async_reset";
    e.exp  = '0;
    sb.push_back(e);
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
    step(mk("post_reset_tick",  0, 0, 0, 1, d(0,0,0,0), d(0,0,0,0), F_IDLE));
    step(mk("post_reset_start", 0, 1, 0, 0, d(0,0,0,0), d(0,0,0,0), F_IDLE));
    step(mk("post_reset_tick2", 0, 0, 0, 1, d(0,0,0,0), d(0,0,0,0), F_IDLE));

    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("[TB] FAIL scoreboard_leftover got=%0d entries required=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
